can_error_frame_gen: RTL and testbench

CAN_ERROR_FRAME_GEN -- requirements
Module: can_error_frame_gen

---
 rtl/can_error_frame_gen.sv | 180 ++++++++++++++++++
 tb/tb_can_error_frame_gen.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_error_frame_gen.sv
// CAN error frame generator: sends a 6-bit error flag, then an 8-bit recessive delimiter.
// Latency: one clk from the triggering sample_point or bus_off/rst edge to the registered outputs.
// Backpressure: none. Error pulses are accepted only in IDLE and are dropped while a frame is in progress.
module can_error_frame_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_point,
    input  logic       rx_bit,
    input  logic       bit_error,
    input  logic       stuff_error,
    input  logic       crc_error,
    input  logic       form_error,
    input  logic       ack_error,
    input  logic       error_passive,
    input  logic       bus_off,
    output logic       tx_bit,
    output logic       err_frame_active,
    output logic       dominant_after_flag,
    output logic       delim_form_error,
    output logic       frame_done,
    output logic [4:0] err_cause
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FLAG       = 2'd1,
        WAIT_DELIM = 2'd2,
        DELIM      = 2'd3
    } state_t;

    // The flag ends on the sample with flag_cnt == 5, which gives six flag bits.
    localparam logic [2:0] FLAG_LAST  = 3'd5;
    // The first recessive delimiter bit is counted in WAIT_DELIM, so delim_cnt == 7 marks the eighth bit.
    localparam logic [2:0] DELIM_LAST = 3'd7;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] flag_cnt;
    logic [2:0] flag_cnt_nxt;
    logic [2:0] delim_cnt;
    logic [2:0] delim_cnt_nxt;
    logic       pending;
    logic       pending_nxt;
    logic       passive_mode;
    logic       passive_mode_nxt;
    logic [4:0] cause_nxt;
    logic       tx_nxt;
    logic       active_nxt;
    logic       dom_nxt;
    logic       dfe_nxt;
    logic       done_nxt;

    logic [4:0] err_in;
    logic       err_any;

    assign err_in  = {bit_error, stuff_error, crc_error, form_error, ack_error};
    assign err_any = |err_in;

    // Next-state logic and next-output logic. bus_off overrides everything else.
    always_comb begin
        state_nxt        = state;
        flag_cnt_nxt     = flag_cnt;
        delim_cnt_nxt    = delim_cnt;
        pending_nxt      = pending;
        passive_mode_nxt = passive_mode;
        cause_nxt        = err_cause;
        dom_nxt          = 1'b0;
        dfe_nxt          = 1'b0;
        done_nxt         = 1'b0;

        if (bus_off) begin
            state_nxt     = IDLE;
            flag_cnt_nxt  = 3'd0;
            delim_cnt_nxt = 3'd0;
            pending_nxt   = 1'b0;
            cause_nxt     = 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (err_any) begin
                        pending_nxt = 1'b1;
                        cause_nxt   = err_cause | err_in;
                    end
                    // An error arriving on the sample itself starts the flag on that bit.
                    if (sample_point && (pending || err_any)) begin
                        state_nxt        = FLAG;
                        flag_cnt_nxt     = 3'd0;
                        delim_cnt_nxt    = 3'd0;
                        passive_mode_nxt = error_passive;
                        pending_nxt      = 1'b0;
                    end
                end

                FLAG: begin
                    if (sample_point) begin
                        if (flag_cnt == FLAG_LAST) begin
                            state_nxt    = WAIT_DELIM;
                            flag_cnt_nxt = 3'd0;
                        end else begin
                            flag_cnt_nxt = flag_cnt + 3'd1;
                        end
                    end
                end

                WAIT_DELIM: begin
                    // Other nodes may still be flagging; keep waiting for the first recessive bit.
                    if (sample_point) begin
                        if (!rx_bit) begin
                            dom_nxt = 1'b1;
                        end else begin
                            state_nxt     = DELIM;
                            delim_cnt_nxt = 3'd1;
                        end
                    end
                end

                DELIM: begin
                    if (sample_point) begin
                        if (!rx_bit) begin
                            // A corrupted delimiter is a form error and restarts the flag.
                            dfe_nxt          = 1'b1;
                            cause_nxt[1]     = 1'b1;
                            state_nxt        = FLAG;
                            flag_cnt_nxt     = 3'd0;
                            delim_cnt_nxt    = 3'd0;
                            passive_mode_nxt = error_passive;
                        end else if (delim_cnt == DELIM_LAST) begin
                            done_nxt      = 1'b1;
                            cause_nxt     = 5'd0;
                            state_nxt     = IDLE;
                            delim_cnt_nxt = 3'd0;
                        end else begin
                            delim_cnt_nxt = delim_cnt + 3'd1;
                        end
                    end
                end

                default: begin
                    state_nxt     = IDLE;
                    flag_cnt_nxt  = 3'd0;
                    delim_cnt_nxt = 3'd0;
                end
            endcase
        end

        // Outputs are computed from the next state so that the registered values line up with it.
        tx_nxt     = !((state_nxt == FLAG) && !passive_mode_nxt);
        active_nxt = (state_nxt != IDLE);
    end

    // State, counters and registered outputs. Synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            flag_cnt            <= 3'd0;
            delim_cnt           <= 3'd0;
            pending             <= 1'b0;
            passive_mode        <= 1'b0;
            err_cause           <= 5'd0;
            tx_bit              <= 1'b1;
            err_frame_active    <= 1'b0;
            dominant_after_flag <= 1'b0;
            delim_form_error    <= 1'b0;
            frame_done          <= 1'b0;
        end else begin
            state               <= state_nxt;
            flag_cnt            <= flag_cnt_nxt;
            delim_cnt           <= delim_cnt_nxt;
            pending             <= pending_nxt;
            passive_mode        <= passive_mode_nxt;
            err_cause           <= cause_nxt;
            tx_bit              <= tx_nxt;
            err_frame_active    <= active_nxt;
            dominant_after_flag <= dom_nxt;
            delim_form_error    <= dfe_nxt;
            frame_done          <= done_nxt;
        end
    end

endmodule

// File: tb/tb_can_error_frame_gen.sv
// Bench for can_error_frame_gen: directed scenarios plus random traffic checked against a behavioural model.
// Latency: each tick drives inputs, waits one clk, then steps the model; outputs are compared 1 ns after the edge.
// Backpressure: not applicable.
module tb_can_error_frame_gen;

    logic       clk;
    logic       rst;
    logic       sample_point;
    logic       rx_bit;
    logic       bit_error;
    logic       stuff_error;
    logic       crc_error;
    logic       form_error;
    logic       ack_error;
    logic       error_passive;
    logic       bus_off;
    logic       tx_bit;
    logic       err_frame_active;
    logic       dominant_after_flag;
    logic       delim_form_error;
    logic       frame_done;
    logic [4:0] err_cause;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    can_error_frame_gen dut (
        .clk                 (clk),
        .rst                 (rst),
        .sample_point        (sample_point),
        .rx_bit              (rx_bit),
        .bit_error           (bit_error),
        .stuff_error         (stuff_error),
        .crc_error           (crc_error),
        .form_error          (form_error),
        .ack_error           (ack_error),
        .error_passive       (error_passive),
        .bus_off             (bus_off),
        .tx_bit              (tx_bit),
        .err_frame_active    (err_frame_active),
        .dominant_after_flag (dominant_after_flag),
        .delim_form_error    (delim_form_error),
        .frame_done          (frame_done),
        .err_cause           (err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model. A frame is tracked as flag bits still owed plus the run of recessive bits seen after the flag.
    bit         m_in_frame;
    int         m_flag_left;
    int         m_rec_run;
    bit         m_passive;
    bit         m_pending;
    logic [4:0] m_cause;
    bit         m_dom;
    bit         m_dfe;
    bit         m_done;

    task automatic model_step();
        logic [4:0] e;
        e = {bit_error, stuff_error, crc_error, form_error, ack_error};
        m_dom  = 0;
        m_dfe  = 0;
        m_done = 0;
        if (rst) begin
            m_in_frame  = 0;
            m_flag_left = 0;
            m_rec_run   = 0;
            m_passive   = 0;
            m_pending   = 0;
            m_cause     = 5'd0;
        end else if (bus_off) begin
            m_in_frame = 0;
            m_pending  = 0;
            m_cause    = 5'd0;
        end else if (!m_in_frame) begin
            if (e != 5'd0) begin
                m_pending = 1;
                m_cause   = m_cause | e;
            end
            if (sample_point && m_pending) begin
                m_in_frame  = 1;
                m_flag_left = 6;
                m_rec_run   = 0;
                m_passive   = error_passive;
                m_pending   = 0;
            end
        end else if (sample_point) begin
            if (m_flag_left > 0) begin
                m_flag_left--;
            end else if (rx_bit) begin
                m_rec_run++;
                if (m_rec_run == 8) begin
                    m_in_frame = 0;
                    m_done     = 1;
                    m_cause    = 5'd0;
                end
            end else if (m_rec_run == 0) begin
                m_dom = 1;
            end else begin
                m_dfe       = 1;
                m_cause[1]  = 1'b1;
                m_flag_left = 6;
                m_rec_run   = 0;
                m_passive   = error_passive;
            end
        end
    endtask

    function automatic logic [9:0] exp_vec();
        logic m_tx;
        m_tx = !(m_in_frame && (m_flag_left > 0) && !m_passive);
        return {m_tx, m_in_frame, m_dom, m_dfe, m_done, m_cause};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {tx_bit, err_frame_active, dominant_after_flag, delim_form_error, frame_done, err_cause};
    endfunction

    // Apply one clock of stimulus; e_i is {bit,stuff,crc,form,ack}.
    task automatic tick(input logic sp_i, input logic rx_i, input logic [4:0] e_i,
                        input logic ep_i, input logic bo_i, input logic rst_i);
        sample_point = sp_i;
        rx_bit       = rx_i;
        {bit_error, stuff_error, crc_error, form_error, ack_error} = e_i;
        error_passive = ep_i;
        bus_off       = bo_i;
        rst           = rst_i;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 5'b11111, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_first cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
        end
        tick(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if ({tx_bit, err_frame_active, dominant_after_flag, delim_form_error, frame_done, err_cause} !== 10'b1_0_0_0_0_00000) begin
            n_bad++;
            $display("FAIL reset_values cyc=%0d got=%b exp=%b", cyc, dut_vec(), 10'b1000000000);
        end
        for (int c = 0; c < 6; c++) begin
            tick(c % 3 == 2, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_no_pending cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_error_active();
        int tx0  = 0;
        int done = 0;
        tick(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 60; c++) begin
            logic sp;
            sp = (c % 3 == 2);
            tick(sp, 1'b1, (c == 2) ? 5'b10000 : 5'b00000, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL active_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (sp && tx_bit === 1'b0) tx0++;
            if (frame_done === 1'b1) done++;
            if (c == 2) begin
                n_vec++;
                if ({err_frame_active, tx_bit, err_cause} !== {1'b1, 1'b0, 5'b10000}) begin
                    n_bad++;
                    $display("FAIL active_same_step cyc=%0d got=%b exp=%b", cyc,
                             {err_frame_active, tx_bit, err_cause}, {1'b1, 1'b0, 5'b10000});
                end
            end
        end
        n_vec++;
        if (tx0 != 6) begin
            n_bad++;
            $display("FAIL active_flag_len got=%0d exp=6", tx0);
        end
        n_vec++;
        if (done != 1) begin
            n_bad++;
            $display("FAIL active_done_cnt got=%0d exp=1", done);
        end
    endtask

    task automatic test_error_passive();
        int act    = 0;
        int done   = 0;
        int tx_low = 0;
        tick(1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 60; c++) begin
            logic sp;
            logic ep;
            sp = (c % 3 == 2);
            ep = (c < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            if (sp && err_frame_active === 1'b1) act++;
            tick(sp, 1'b1, (c == 0) ? 5'b00100 : 5'b00000, ep, 1'b0, 1'b0);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL passive_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (tx_bit !== 1'b1) tx_low++;
            if (frame_done === 1'b1) done++;
        end
        n_vec++;
        if (act != 14) begin
            n_bad++;
            $display("FAIL passive_active_len got=%0d exp=14", act);
        end
        n_vec++;
        if (tx_low != 0 || done != 1) begin
            n_bad++;
            $display("FAIL passive_tx_done got=tx_low:%0d done:%0d exp=tx_low:0 done:1", tx_low, done);
        end
    endtask

    task automatic test_superposition();
        int s    = 0;
        int dom  = 0;
        int done = 0;
        tick(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 72; c++) begin
            logic sp;
            logic rx;
            sp = (c % 3 == 2);
            if (sp) s++;
            rx = !(sp && s >= 8 && s <= 10);
            tick(sp, rx, (c == 0) ? 5'b00010 : 5'b00000, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL super_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (dominant_after_flag === 1'b1) dom++;
            if (frame_done === 1'b1) done++;
        end
        n_vec++;
        if (dom != 3 || done != 1) begin
            n_bad++;
            $display("FAIL super_counts got=dom:%0d done:%0d exp=dom:3 done:1", dom, done);
        end
    endtask

    task automatic test_delim_corruption();
        int s    = 0;
        int tx0  = 0;
        int dfe  = 0;
        int done = 0;
        tick(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 90; c++) begin
            logic sp;
            logic rx;
            sp = (c % 3 == 2);
            if (sp) s++;
            rx = !(sp && s == 11);
            tick(sp, rx, (c == 0) ? 5'b00001 : 5'b00000, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL delim_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (sp && tx_bit === 1'b0) tx0++;
            if (frame_done === 1'b1) done++;
            if (delim_form_error === 1'b1) begin
                dfe++;
                n_vec++;
                if (err_cause !== 5'b00011) begin
                    n_bad++;
                    $display("FAIL delim_cause cyc=%0d got=%b exp=%b", cyc, err_cause, 5'b00011);
                end
            end
        end
        n_vec++;
        if (dfe != 1 || tx0 != 12 || done != 1) begin
            n_bad++;
            $display("FAIL delim_counts got=dfe:%0d tx0:%0d done:%0d exp=dfe:1 tx0:12 done:1", dfe, tx0, done);
        end
    endtask

    task automatic test_bus_off();
        int leaked = 0;
        tick(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 75; c++) begin
            logic       sp;
            logic       bo;
            logic [4:0] e;
            sp = (c % 3 == 2);
            bo = (c >= 10 && c < 40);
            e  = (c == 0) ? 5'b01000 : (bo ? 5'($urandom_range(0, 31)) : 5'b00000);
            tick(sp, 1'b1, e, 1'b0, bo, 1'b0);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL busoff_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (c == 10) begin
                n_vec++;
                if ({err_frame_active, tx_bit, err_cause} !== 7'b0_1_00000) begin
                    n_bad++;
                    $display("FAIL busoff_abort cyc=%0d got=%b exp=%b", cyc,
                             {err_frame_active, tx_bit, err_cause}, 7'b0100000);
                end
            end
            if (c > 10 && err_frame_active !== 1'b0) leaked++;
        end
        n_vec++;
        if (leaked != 0) begin
            n_bad++;
            $display("FAIL busoff_no_flag got=%0d exp=0", leaked);
        end
    endtask

    task automatic test_rst_mid_frame();
        int tx0  = 0;
        int done = 0;
        tick(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 96; c++) begin
            logic       sp;
            logic [4:0] e;
            sp = (c % 3 == 2) && (c != 30);
            e  = (c == 0) ? 5'b10000 : ((c == 40) ? 5'b00100 : 5'b00000);
            tick(sp, 1'b1, e, 1'b0, 1'b0, c == 30);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rst_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (c == 30) begin
                n_vec++;
                if (dut_vec() !== 10'b1000000000) begin
                    n_bad++;
                    $display("FAIL rst_abort cyc=%0d got=%b exp=%b", cyc, dut_vec(), 10'b1000000000);
                end
            end
            if (c > 30 && sp && tx_bit === 1'b0) tx0++;
            if (c > 30 && frame_done === 1'b1) done++;
            if (c > 40 && err_frame_active === 1'b1 && err_cause !== 5'b00100) begin
                n_vec++;
                n_bad++;
                $display("FAIL rst_residual_cause cyc=%0d got=%b exp=%b", cyc, err_cause, 5'b00100);
            end
        end
        n_vec++;
        if (tx0 != 6 || done != 1) begin
            n_bad++;
            $display("FAIL rst_clean_flag got=tx0:%0d done:%0d exp=tx0:6 done:1", tx0, done);
        end
    endtask

    task automatic test_random();
        logic ep      = 1'b0;
        int   bo_left = 0;
        tick(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4000; c++) begin
            logic       sp;
            logic       rx;
            logic       r;
            logic [4:0] e;
            sp = ($urandom_range(0, 2) == 0);
            rx = ($urandom_range(0, 7) != 0);
            for (int b = 0; b < 5; b++) e[b] = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 49) == 0) ep = ~ep;
            if (bo_left > 0) bo_left--;
            else if ($urandom_range(0, 299) == 0) bo_left = $urandom_range(1, 10);
            r = ($urandom_range(0, 499) == 0);
            tick(sp, rx, e, ep, bo_left > 0, r);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        sample_point  = 1'b0;
        rx_bit        = 1'b1;
        bit_error     = 1'b0;
        stuff_error   = 1'b0;
        crc_error     = 1'b0;
        form_error    = 1'b0;
        ack_error     = 1'b0;
        error_passive = 1'b0;
        bus_off       = 1'b0;
        m_in_frame    = 0;
        m_flag_left   = 0;
        m_rec_run     = 0;
        m_passive     = 0;
        m_pending     = 0;
        m_cause       = 5'd0;
        m_dom         = 0;
        m_dfe         = 0;
        m_done        = 0;

        test_reset();
        test_error_active();
        test_error_passive();
        test_superposition();
        test_delim_corruption();
        test_bus_off();
        test_rst_mid_frame();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
